prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
- Parametrised, runtime-programmable clock divider / tick generator; successor to the fixed divide-by-500 block.
- Produces a registered output per divisor period D, in either single-cycle pulse mode or near-50% square mode.
- D and mode are reprogrammable without glitches: changes apply only at the period boundary.
- Feeds slow-clock enables (display scan, debounce, single-step) in the processor top level.

Parameters:
- WIDTH, 16, width of the divisor and counter; legal D range is 2 .. 2^WIDTH-1.
- DEFAULT_DIV, 500, divisor loaded at reset; must be within 2 .. 2^WIDTH-1.
- DEFAULT_MODE, 0, mode loaded at reset: 0 = pulse, 1 = square.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- enable  in  1  1 = count; 0 = hold counter, force output low.
- div_value  in  WIDTH  requested divisor D.
- mode_value  in  1  requested mode.
- div_load  in  1  single-cycle strobe; captures div_value and mode_value.
- clock_out  out  1  registered divided output.
- load_pending  out  1  a captured request is waiting for the period boundary.
- cur_div  out  WIDTH  divisor currently in effect.
- count  out  WIDTH  current counter value q.

Behaviour:
- Reset (synchronous, overrides everything):
  - q=0, div_r=DEFAULT_DIV, mode_r=DEFAULT_MODE.
  - pend_div=0, pend_mode=0, load_pending=0, clock_out=0.
- Counter:
  - q counts 0..div_r-1 while enable=1.
  - terminal = enable & (q == div_r-1).
  - At terminal, q wraps to 0 on the next edge.
- Cycle numbering: cycle 0 is the first cycle with q=0 after reset release or after a restart.
- Pulse mode (mode_r=0):
  - clock_out <= terminal, so it is a one-cycle high.
  - First pulse is in cycle D, then every D cycles (2D, 3D, ...).
  - Duty is exactly 1/D.
- Square mode (mode_r=1):
  - clock_out <= enable & (q < ceil(D/2)).
  - High for ceil(D/2) cycles, low for floor(D/2) cycles, with one cycle of register latency.
  - Example: D=5 gives 3 high, 2 low; the first high is cycle 1.
- Divisor clamp: any captured div_value < 2 is replaced by 2. No other range check.
- Loading while enable=1:
  - div_load stores into pend_div/pend_mode and sets load_pending.
  - On the next terminal cycle, div_r/mode_r take the pending values, q wraps to 0, and load_pending clears.
  - The current period always completes with the old divisor and mode; no runt or stretched pulse.
- Multiple div_load before the boundary: the last one wins.
- div_load in the terminal cycle itself: the strobed value is applied directly at that wrap (it beats any older pending value); load_pending stays 0.
- Loading while enable=0:
  - div_load writes div_r/mode_r immediately and clears q to 0.
  - load_pending stays 0; any older pending request is discarded.
- enable=0 (hold):
  - q holds; clock_out goes 0 on the next edge.
  - Pending request is retained and not applied.
- enable 0->1: counting resumes from the held q; no period restart.
- Reset mid-period or with a request pending: the pending request is lost and defaults are restored.
- cur_div = div_r and count = q, both combinational from registers.
- Counter arithmetic is WIDTH bits unsigned; q never exceeds div_r-1 because div_r is only changed at wrap or while q is cleared.

Test Plan:
- Reset, default params, enable=1 -> clock_out high for 1 cycle at cycles 500, 1000, 1500; low elsewhere; cur_div=500.
- Disabled (enable=0): div_load div_value=5, mode_value=1; then enable=1 -> cur_div=5 immediately; clock_out pattern H,H,H,L,L repeating from cycle 1.
- Running pulse mode D=10: at q=3, load div_value=4 -> load_pending=1 until q=9; pulse at the old boundary; next pulses at 4-cycle spacing; load_pending=0 after the wrap.
- D=10: loads of 7 then 3 before the boundary -> only 3 is applied; pulses spaced 10 then 3.
- Load div_value=0 and, separately, div_value=1 -> cur_div=2; pulse mode toggles pulse every 2nd cycle.
- D=8 running: enable=0 for 5 cycles at q=4 -> count frozen at 4, clock_out=0. Then, with a pending request, assert reset -> cur_div=500, load_pending=0, count=0, clock_out=0.

Source files
------------

// File: rtl/prog_clock_divider.sv
// -----------------------------------------------------------------------------
// prog_clock_divider
//   Runtime-programmable clock divider / tick generator. Produces a registered
//   output once per divisor period D, either as a single-cycle pulse (mode 0)
//   or as a near-50% square wave (mode 1, high for ceil(D/2) cycles).
//   Divisor and mode changes made while counting wait for the period boundary,
//   so the output never shows a runt or stretched period.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   enable       in   1 = count, 0 = hold counter and force output low
//   div_value    in   requested divisor (values below 2 are clamped to 2)
//   mode_value   in   requested mode (0 = pulse, 1 = square)
//   div_load     in   single-cycle strobe capturing div_value/mode_value
//   clock_out    out  registered divided output
//   load_pending out  a captured request is waiting for the period boundary
//   cur_div      out  divisor currently in effect
//   count        out  current counter value
// -----------------------------------------------------------------------------
module prog_clock_divider #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 500,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_value,
  input  logic             mode_value,
  input  logic             div_load,
  output logic             clock_out,
  output logic             load_pending,
  output logic [WIDTH-1:0] cur_div,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic             DEF_MODE = 1'(DEFAULT_MODE);
  localparam logic [WIDTH-1:0] MIN_DIV  = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             mode_q, mode_d;
  logic             pend_mode_q, pend_mode_d;
  logic             pending_q, pending_d;
  logic             out_q, out_d;

  logic [WIDTH-1:0] load_div;
  logic [WIDTH-1:0] half_div;
  logic             terminal;

  assign load_div = (div_value < MIN_DIV) ? MIN_DIV : div_value;
  assign terminal = enable && (q_q == div_q - ONE);
  // ceil(D/2) without needing an extra bit for D+1
  assign half_div = (div_q >> 1) + {{(WIDTH-1){1'b0}}, div_q[0]};

  always_comb begin
    q_d         = q_q;
    div_d       = div_q;
    mode_d      = mode_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;
    pending_d   = pending_q;
    out_d       = 1'b0;

    if (!enable) begin
      // Idle: a load takes effect at once and restarts the period.
      if (div_load) begin
        div_d     = load_div;
        mode_d    = mode_value;
        q_d       = '0;
        pending_d = 1'b0;
      end
    end else begin
      // Output decision always uses the settings of the period in progress.
      out_d = mode_q ? (q_q < half_div) : terminal;

      if (terminal) begin
        q_d       = '0;
        pending_d = 1'b0;
        if (div_load) begin
          // A strobe in the terminal cycle beats any older pending request.
          div_d  = load_div;
          mode_d = mode_value;
        end else if (pending_q) begin
          div_d  = pend_div_q;
          mode_d = pend_mode_q;
        end
      end else begin
        q_d = q_q + ONE;
        if (div_load) begin
          pend_div_d  = load_div;
          pend_mode_d = mode_value;
          pending_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_q         <= '0;
      div_q       <= DEF_DIV;
      mode_q      <= DEF_MODE;
      pend_div_q  <= '0;
      pend_mode_q <= 1'b0;
      pending_q   <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      q_q         <= q_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
      pending_q   <= pending_d;
      out_q       <= out_d;
    end
  end

  assign clock_out    = out_q;
  assign load_pending = pending_q;
  assign cur_div      = div_q;
  assign count        = q_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] div_value;
  logic        mode_value;
  logic        div_load;
  logic        clock_out;
  logic        load_pending;
  logic [15:0] cur_div;
  logic [15:0] count;

  int vecs = 0;
  int errs = 0;

  prog_clock_divider #(.WIDTH(16), .DEFAULT_DIV(500), .DEFAULT_MODE(0)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .div_value    (div_value),
    .mode_value   (mode_value),
    .div_load     (div_load),
    .clock_out    (clock_out),
    .load_pending (load_pending),
    .cur_div      (cur_div),
    .count        (count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Program divisor/mode while idle; returns on the sample after the load edge.
  task automatic prog_disabled(input logic [15:0] d, input logic m);
    enable     = 1'b0;
    div_load   = 1'b1;
    div_value  = d;
    mode_value = m;
    tick();
    div_load   = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    div_value  = '0;
    mode_value = 1'b0;
    div_load   = 1'b0;
    tick();
    tick();

    // ---- reset state, default divide-by-500 pulse mode
    check("rst_clock_out", clock_out, 0);
    check("rst_count", count, 0);
    check("rst_cur_div", cur_div, 500);
    check("rst_pending", load_pending, 0);
    reset = 1'b0;
    for (int k = 1; k <= 1500; k++) begin
      tick();
      check("def_pulse", clock_out, (k % 500 == 0) ? 1 : 0);
      if (k == 499) check("def_cnt499", count, 499);
      if (k == 500) check("def_cnt_wrap", count, 0);
    end
    check("def_cur_div", cur_div, 500);

    // ---- idle load D=5 square mode
    prog_disabled(16'd5, 1'b1);
    check("idle_cur_div", cur_div, 5);
    check("idle_count", count, 0);
    check("idle_out_low", clock_out, 0);
    check("idle_pending", load_pending, 0);
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("sq5_out", clock_out, ((k % 5) >= 1 && (k % 5) <= 3) ? 1 : 0);
    end

    // ---- D=10 running, load 4 at q=3
    prog_disabled(16'd10, 1'b0);
    enable = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      check("ld4_out", clock_out, (k == 10 || k == 14 || k == 18 || k == 22) ? 1 : 0);
      check("ld4_pend", load_pending, (k >= 4 && k < 10) ? 1 : 0);
      check("ld4_div", cur_div, (k < 10) ? 10 : 4);
      div_load = (k == 3);
      div_value = 16'd4;
    end
    div_load = 1'b0;

    // ---- D=10, loads 7 then 3: last wins
    prog_disabled(16'd10, 1'b0);
    enable = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      check("lw_out", clock_out, (k == 10 || k == 13 || k == 16 || k == 19) ? 1 : 0);
      check("lw_pend", load_pending, (k >= 3 && k <= 9) ? 1 : 0);
      check("lw_div", cur_div, (k < 10) ? 10 : 3);
      if (k == 10) check("lw_cnt", count, 0);
      div_load  = (k == 2 || k == 5);
      div_value = (k == 2) ? 16'd7 : 16'd3;
    end
    div_load = 1'b0;

    // ---- load in terminal cycle beats pending; running load of 1 clamps to 2
    prog_disabled(16'd10, 1'b0);
    enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("tl_out", clock_out, (k == 10 || k == 13 || k == 15 || k == 17) ? 1 : 0);
      check("tl_pend", load_pending, ((k >= 3 && k <= 9) || k == 12) ? 1 : 0);
      check("tl_div", cur_div, (k < 10) ? 10 : (k < 13) ? 3 : 2);
      div_load  = (k == 2 || k == 9 || k == 11);
      div_value = (k == 2) ? 16'd7 : (k == 9) ? 16'd3 : 16'd1;
    end
    div_load = 1'b0;

    // ---- idle load of 0 clamps to 2
    prog_disabled(16'd0, 1'b0);
    check("clamp0_div", cur_div, 2);
    enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("clamp0_out", clock_out, (k % 2 == 0) ? 1 : 0);
      check("clamp0_cnt", count, k % 2);
    end

    // ---- D=8: hold at q=4, resume, then reset with a request pending
    prog_disabled(16'd8, 1'b0);
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("hold_cnt", count, (k <= 4) ? k : (k <= 9) ? 4 : (k <= 12) ? k - 5 : (k <= 15) ? k - 13 : 0);
      check("hold_out", clock_out, (k == 13) ? 1 : 0);
      check("hold_pend", load_pending, ((k >= 3 && k <= 12) || k == 15) ? 1 : 0);
      check("hold_div", cur_div, (k <= 12) ? 8 : (k <= 15) ? 6 : 500);
      div_load  = (k == 2 || k == 14);
      div_value = (k == 2) ? 16'd6 : 16'd3;
      if (k == 4) enable = 1'b0;
      if (k == 9) enable = 1'b1;
      reset = (k == 15);
    end
    div_load = 1'b0;
    reset    = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
